// File: rtl/fetch_stage_sequencer.sv
// Multi-cycle IF/ID/EX/WB front end: owns the PC, fetches over a req/ready
// handshake, applies branch redirects and retires one instruction per WB.
module fetch_stage_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [1:0]  stage,
    output logic [31:0] pc,
    input  logic        branch_instruction,
    input  logic [31:0] immediate,
    input  logic        branch_taken,
    input  logic        ex_done,
    output logic        fetch_fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        ST_IF = 2'b00,
        ST_ID = 2'b01,
        ST_EX = 2'b10,
        ST_WB = 2'b11
    } stage_t;

    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam bit          TIMEOUT_EN   = (FETCH_TIMEOUT != 0);
    localparam logic [31:0] TIMEOUT_LAST = 32'(FETCH_TIMEOUT - 1);

    stage_t      state, state_n;
    logic [31:0] next_pc, next_pc_n;
    logic [31:0] pc_n, instr_n, count_n, wait_cnt, wait_n;
    logic        fault_n;
    logic [1:0]  cause_n;
    logic [31:0] target;

    assign stage     = state;
    assign imem_addr = pc;
    assign imem_req  = (state == ST_IF) & ~fetch_fault & ~rst;

    // A fault freezes everything; stage is already IF when a fault is raised.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        next_pc_n = next_pc;
        instr_n   = instruction;
        count_n   = instr_count;
        fault_n   = fetch_fault;
        cause_n   = fault_cause;
        wait_n    = wait_cnt;
        target    = pc + ((branch_instruction & branch_taken) ? immediate : 32'd4);

        if (!fetch_fault) begin
            case (state)
                ST_IF: begin
                    if (imem_ready) begin
                        instr_n = imem_rdata;
                        state_n = ST_ID;
                        wait_n  = '0;
                    end else if (TIMEOUT_EN && wait_cnt == TIMEOUT_LAST) begin
                        fault_n = 1'b1;
                        cause_n = 2'b01;
                    end else if (TIMEOUT_EN) begin
                        wait_n = wait_cnt + 32'd1;
                    end
                end
                ST_ID: state_n = ST_EX;
                ST_EX: begin
                    if (ex_done) begin
                        if (target[1:0] != 2'b00) begin
                            fault_n = 1'b1;
                            cause_n = 2'b10;
                            state_n = ST_IF;
                        end else begin
                            next_pc_n = target;
                            state_n   = ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    pc_n    = next_pc;
                    count_n = instr_count + 32'd1;
                    state_n = ST_IF;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IF;
            pc          <= RESET_PC;
            next_pc     <= RESET_PC;
            instruction <= NOP;
            instr_count <= '0;
            fetch_fault <= 1'b0;
            fault_cause <= 2'b00;
            wait_cnt    <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            next_pc     <= next_pc_n;
            instruction <= instr_n;
            instr_count <= count_n;
            fetch_fault <= fault_n;
            fault_cause <= cause_n;
            wait_cnt    <= wait_n;
        end
    end

endmodule
